// File: rtl/sat_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_model_pkg
// Description : Shared constants, node state encoding and the saturating
//               clamp helper for the saturating switch-level chip model.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_model_pkg;

    // Rail voltages used as default presets by node models
    localparam int HI = 64;
    localparam int LO = -64;

    // Current magnitudes injected by the resistive pull models
    localparam int PULLUP_STRENGTH   = 2;
    localparam int PULLDOWN_STRENGTH = 3;

    // Node integrator state
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        SETTLED = 1'b1
    } node_state_e;

    // Clamp a wide signed value into the signed range of a w-bit word
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] value,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (value > hi)
            return hi;
        else if (value < lo)
            return lo;
        else
            return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/node_saturating_current_sum.sv
`default_nettype none
// ============================================================================
// Module      : current_sum
// Description : Combinational signed sum of N packed current contributions,
//               widened so the total can never wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module current_sum #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SUM_W = W + $clog2(N) + 1
) (
    input  logic [N*W-1:0]          i_bus,
    output logic signed [SUM_W-1:0] sum
);

    // Sign-extend every contribution to the full sum width and accumulate
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + SUM_W'($signed(i_bus[k*W +: W]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/node_saturating.sv
`default_nettype none
// ============================================================================
// Module      : node_saturating
// Description : Clocked node integrator. Adds the summed node current to the
//               stored voltage with saturation, and flags quiescence after a
//               run of unchanged-voltage steps.
// Revision    : 1.0 - initial release
// ============================================================================
module node_saturating
    import sat_model_pkg::*;
#(
    parameter int                   W      = 8,
    parameter int                   N      = 4,
    parameter logic signed [W-1:0]  V_INIT = W'(LO),
    parameter int                   SETTLE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    step,
    input  logic                    load,
    input  logic signed [W-1:0]     load_v,
    input  logic [N*W-1:0]          i_bus,
    output logic signed [W-1:0]     v,
    output logic                    level,
    output logic                    settled,
    output logic [3:0]              stable_cnt
);

    // One guard bit for the voltage add on top of the current-sum growth
    localparam int c_SUM_W = W + $clog2(N) + 1;

    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [c_SUM_W-1:0] w_next;
    logic signed [W-1:0]       w_clamped;
    logic                      w_same;
    logic [3:0]                w_cnt_inc;
    logic                      w_reach;

    logic signed [W-1:0]       r_v;
    logic [3:0]                r_cnt;
    logic                      r_settled;
    node_state_e               r_state;

    current_sum #(
        .W     (W),
        .N     (N),
        .SUM_W (c_SUM_W)
    ) u_current_sum (
        .i_bus (i_bus),
        .sum   (w_sum)
    );

    // Candidate voltage: wide add, then clamp to the W-bit signed range
    assign w_next    = c_SUM_W'(r_v) + w_sum;
    assign w_clamped = W'(sat_clamp(64'(w_next), W));

    // A clamped result equal to the present voltage counts as unchanged,
    // so a node pinned at a rail by an opposing driver still settles
    assign w_same    = (w_clamped == r_v);
    assign w_cnt_inc = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
    assign w_reach   = (w_cnt_inc >= 4'(SETTLE));

    // Voltage register, stability counter and RUN/SETTLED state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v       <= V_INIT;
            r_cnt     <= 4'd0;
            r_settled <= 1'b0;
            r_state   <= RUN;
        end else if (load) begin
            r_v       <= load_v;
            r_cnt     <= 4'd0;
            r_settled <= 1'b0;
            r_state   <= RUN;
        end else if (step) begin
            r_v   <= w_clamped;
            r_cnt <= w_same ? w_cnt_inc : 4'd0;
            case (r_state)
                RUN: begin
                    if (w_same && w_reach) begin
                        r_state   <= SETTLED;
                        r_settled <= 1'b1;
                    end
                end
                SETTLED: begin
                    if (!w_same) begin
                        r_state   <= RUN;
                        r_settled <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RUN;
                    r_settled <= 1'b0;
                end
            endcase
        end
    end

    assign v          = r_v;
    assign level      = ~r_v[W-1];
    assign settled    = r_settled;
    assign stable_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_node_saturating.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_saturating
// Description : Scoreboard bench for node_saturating with an integer
//               reference model of the node voltage and settle detection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_saturating;

    localparam int W      = 8;
    localparam int N      = 4;
    localparam int SETTLE = 3;
    localparam int VINIT  = -64;

    logic               clk = 1'b0;
    logic               reset;
    logic               step;
    logic               load;
    logic signed [W-1:0] load_v;
    logic [N*W-1:0]     i_bus;
    logic signed [W-1:0] v;
    logic               level;
    logic               settled;
    logic [3:0]         stable_cnt;

    node_saturating #(
        .W      (W),
        .N      (N),
        .V_INIT (8'(VINIT)),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .load       (load),
        .load_v     (load_v),
        .i_bus      (i_bus),
        .v          (v),
        .level      (level),
        .settled    (settled),
        .stable_cnt (stable_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        bit s;
        int c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_v   = VINIT;
    int m_cnt = 0;
    bit m_set = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock of stimulus; the model's post-edge expectation is queued
    task automatic cycle(input bit rst, input bit ld, input int lv, input bit st,
                         input int c0, input int c1, input int c2, input int c3);
        int   nxt;
        exp_t e;
        @(negedge clk);
        reset  = rst;
        load   = ld;
        load_v = 8'(lv);
        step   = st;
        i_bus  = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        if (rst) begin
            m_v = VINIT; m_cnt = 0; m_set = 0;
        end else if (ld) begin
            m_v = lv; m_cnt = 0; m_set = 0;
        end else if (st) begin
            nxt = m_v + c0 + c1 + c2 + c3;
            if (nxt > 127)  nxt = 127;
            if (nxt < -128) nxt = -128;
            if (nxt == m_v) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            else            m_cnt = 0;
            if (nxt != m_v)            m_set = 0;
            else if (m_cnt >= SETTLE)  m_set = 1;
            m_v = nxt;
        end
        e.v = m_v; e.s = m_set; e.c = m_cnt;
        q.push_back(e);
    endtask

    task automatic stepi(input int c0, input int c1);
        cycle(0, 0, 0, 1, c0, c1, 0, 0);
    endtask

    // Wait past the next edge so directed checks see the updated outputs
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare each registered update against the queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_v", int'(v), e.v);
                chk("sb_level", int'(level), (e.v < 0) ? 0 : 1);
                chk("sb_settled", int'(settled), int'(e.s));
                chk("sb_cnt", int'(stable_cnt), e.c);
            end
        end
    end

    initial begin : stim
        int c0, c1, c2, c3, r;
        reset = 1'b1; load = 1'b0; load_v = '0; step = 1'b0; i_bus = '0;

        // Reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("reset_v", int'(v), -64);
        chk("reset_level", int'(level), 0);
        chk("reset_settled", int'(settled), 0);
        chk("reset_cnt", int'(stable_cnt), 0);

        // Pullup only: ten steps of +2
        for (int i = 0; i < 10; i++) stepi(2, 0);
        after_edge();
        chk("pullup_v", int'(v), -44);
        chk("pullup_level", int'(level), 0);
        chk("pullup_settled", int'(settled), 0);

        // Saturation at the positive rail
        cycle(0, 1, 120, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) stepi(3, 0);
        after_edge();
        chk("sat_v", int'(v), 127);
        chk("sat_cnt", int'(stable_cnt), 2);
        chk("sat_not_settled", int'(settled), 0);
        stepi(3, 0);
        after_edge();
        chk("sat_settled", int'(settled), 1);

        // Fight: +2 against -3 from zero down to the negative rail
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 128; i++) stepi(2, -3);
        after_edge();
        chk("fight_v", int'(v), -128);
        chk("fight_not_settled", int'(settled), 0);
        for (int i = 0; i < 3; i++) stepi(2, -3);
        after_edge();
        chk("fight_settled", int'(settled), 1);

        // Settle break, then re-settle with zero current
        stepi(2, 0);
        after_edge();
        chk("break_settled", int'(settled), 0);
        chk("break_cnt", int'(stable_cnt), 0);
        for (int i = 0; i < 3; i++) stepi(0, 0);
        after_edge();
        chk("resettle", int'(settled), 1);

        // Load wins over a simultaneous step
        cycle(0, 1, 10, 1, 3, 0, 0, 0);
        after_edge();
        chk("load_step_v", int'(v), 10);
        chk("load_step_cnt", int'(stable_cnt), 0);

        // Reset during a run of steps, then idle with a changing bus
        for (int i = 0; i < 4; i++) stepi(1, 0);
        cycle(1, 0, 0, 1, 5, 0, 0, 0);
        after_edge();
        chk("midreset_v", int'(v), -64);
        chk("midreset_settled", int'(settled), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 17 * i + 3, -9 * i, i, 50);
        after_edge();
        chk("idle_hold_v", int'(v), -64);

        // Randomized traffic; small, often zero currents so settling occurs
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            c0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128 : 0;
            c1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) - 3 : 0;
            c2 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) - 128 : 0;
            c3 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) - 3 : 0;
            if ($urandom_range(0, 1) == 0) begin c0 = 0; c2 = 0; end
            if (r < 2)
                cycle(1, 0, 0, 1, c0, c1, c2, c3);
            else if (r < 6)
                cycle(0, 1, int'($urandom_range(0, 255)) - 128, r[0], c0, c1, c2, c3);
            else if (r < 80)
                cycle(0, 0, 0, 1, c0, c1, c2, c3);
            else
                cycle(0, 0, 0, 0, c0, c1, c2, c3);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
